// File: rtl/shift_add_controller.sv
// -----------------------------------------------------------------------------
// shift_add_controller
//
// Sequencing FSM for a shift-add multiplier. After a start request it loads the
// accumulator, then for each of N_BITS multiplier bits inspects the accumulator
// LSB, optionally arms an add, and shifts. Completion is reported with a level
// done flag that is held until the start request is dropped.
//
// Parameters:
//   N_BITS       multiplier width and number of shift steps (2..16)
//
// Ports:
//   i_CLK        clock, rising edge
//   i_RESET      asynchronous, active-low reset
//   i_START      level start request, only looked at in IDLE
//   i_LSB        accumulator bit 0, only looked at in CHECK
//   o_LOAD_cmd   load operand B / clear upper accumulator (one cycle)
//   o_ADD_cmd    arm the add for the following shift (one cycle)
//   o_SHIFT_cmd  shift the accumulator right by one (one cycle)
//   o_BUSY       high while an operation is in progress
//   o_DONE       result valid, high in DONE only
//   o_CYCLE_CNT  cycles used by the last completed operation
//                (present only when SHIFT_ADD_CTRL_CYCLE_CNT_EN is defined)
//
// Optional feature macro: SHIFT_ADD_CTRL_CYCLE_CNT_EN
// -----------------------------------------------------------------------------
module shift_add_controller #(
  parameter int N_BITS = 4
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic       i_START,
  input  logic       i_LSB,
  output logic       o_LOAD_cmd,
  output logic       o_ADD_cmd,
  output logic       o_SHIFT_cmd,
  output logic       o_BUSY,
  output logic       o_DONE
`ifdef SHIFT_ADD_CTRL_CYCLE_CNT_EN
  ,
  output logic [7:0] o_CYCLE_CNT
`endif
);

  localparam int CW = $clog2(N_BITS + 1);
  // Counter value seen in the final SHIFT; the increment there reaches N_BITS.
  localparam logic [CW-1:0] LAST_STEP = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic          load_d, add_d, shift_d, busy_d, done_d;

  // Next-state and step counter.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      S_IDLE: begin
        step_d = '0;
        if (i_START) state_d = S_LOAD;
      end
      S_LOAD: begin
        step_d  = '0;
        state_d = S_CHECK;
      end
      S_CHECK: state_d = i_LSB ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        step_d  = step_q + 1'b1;
        state_d = (step_q == LAST_STEP) ? S_DONE : S_CHECK;
      end
      S_DONE:  if (!i_START) state_d = S_IDLE;
      default: begin
        // Unused encodings fall back to IDLE on the next edge.
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // flop always reflects the current state without any combinational glitch.
  always_comb begin
    load_d  = (state_d == S_LOAD);
    add_d   = (state_d == S_ADD);
    shift_d = (state_d == S_SHIFT);
    busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK) ||
              (state_d == S_ADD)  || (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_RESET) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      o_LOAD_cmd  <= 1'b0;
      o_ADD_cmd   <= 1'b0;
      o_SHIFT_cmd <= 1'b0;
      o_BUSY      <= 1'b0;
      o_DONE      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      o_LOAD_cmd  <= load_d;
      o_ADD_cmd   <= add_d;
      o_SHIFT_cmd <= shift_d;
      o_BUSY      <= busy_d;
      o_DONE      <= done_d;
    end
  end

`ifdef SHIFT_ADD_CTRL_CYCLE_CNT_EN
  logic [7:0] cyc_q, cyc_d, cyc_inc;
  logic [7:0] cyc_out_d;

  // The running count is cleared at the start edge and advances on every
  // busy cycle; the copy taken on the DONE-entry edge includes that final
  // busy cycle, so it equals the start-to-DONE edge distance.
  always_comb begin
    cyc_inc   = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
    cyc_d     = cyc_q;
    cyc_out_d = o_CYCLE_CNT;
    if ((state_q == S_IDLE) && i_START) cyc_d = 8'd0;
    else if (o_BUSY)                    cyc_d = cyc_inc;
    if ((state_d == S_DONE) && (state_q != S_DONE)) cyc_out_d = cyc_inc;
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      cyc_q       <= 8'd0;
      o_CYCLE_CNT <= 8'd0;
    end else begin
      cyc_q       <= cyc_d;
      o_CYCLE_CNT <= cyc_out_d;
    end
  end
`endif

endmodule

// File: tb/tb_shift_add_controller.sv
// -----------------------------------------------------------------------------
// tb_shift_add_controller
//
// Directed bench for shift_add_controller (N_BITS = 4). A behavioural
// accumulator reacts to the command outputs and feeds i_LSB back, so the
// product it ends with is checked against hand-computed values together with
// DONE latency, pulse counts and per-cycle command invariants.
// -----------------------------------------------------------------------------
module tb_shift_add_controller;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic lsb;
  logic load, add, shift, busy, done;
`ifdef SHIFT_ADD_CTRL_CYCLE_CNT_EN
  logic [7:0] cyc;
`endif

  int tests = 0;
  int fails = 0;
  int loads = 0;
  int adds = 0;
  int shifts = 0;
  logic prev_add = 1'b0;

  // Behavioural accumulator: {upper N+1 bits, lower N bits}.
  logic [3:0] a_op = 4'd0;
  logic [3:0] b_op = 4'd0;
  logic [8:0] acc = 9'd0;
  logic       armed = 1'b0;

  always #5 clk = ~clk;

  assign lsb = acc[0];

  shift_add_controller #(.N_BITS(N)) dut (
    .i_CLK       (clk),
    .i_RESET     (rst_n),
    .i_START     (start),
    .i_LSB       (lsb),
    .o_LOAD_cmd  (load),
    .o_ADD_cmd   (add),
    .o_SHIFT_cmd (shift),
    .o_BUSY      (busy),
    .o_DONE      (done)
`ifdef SHIFT_ADD_CTRL_CYCLE_CNT_EN
    ,
    .o_CYCLE_CNT (cyc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the accumulator with the commands that were present
  // before the edge, then check the per-cycle invariants.
  task automatic step();
    logic l, a, s;
    l = load;
    a = add;
    s = shift;
    @(posedge clk);
    #1;
    if (l) begin
      acc   = {5'd0, b_op};
      armed = 1'b0;
    end
    if (a) armed = 1'b1;
    if (s) begin
      if (armed) acc[8:4] = acc[8:4] + {1'b0, a_op};
      acc   = acc >> 1;
      armed = 1'b0;
    end
    check("cmd_onehot0", {31'd0, $onehot0({load, add, shift})}, 32'd1);
    check("busy_done_excl", {31'd0, busy & done}, 32'd0);
    if (prev_add) check("add_then_shift", {31'd0, shift}, 32'd1);
    prev_add = add;
    loads  += int'(load);
    adds   += int'(add);
    shifts += int'(shift);
  endtask

  // Start an operation from IDLE and follow it into DONE. Start stays high
  // on return unless toggling dropped it.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                        input int exp_adds, input int exp_prod, input bit toggle);
    int l0, a0, s0, lat;
    a_op = a;
    b_op = b;
    l0 = loads;
    a0 = adds;
    s0 = shifts;
    start = 1'b1;
    step();  // edge E0
    check("busy_at_e0", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 60) begin
      step();
      lat++;
      if (toggle && !done) start = ~start;
    end
    check("done_latency", lat, exp_lat);
    check("load_pulses", loads - l0, 32'd1);
    check("add_pulses", adds - a0, exp_adds);
    check("shift_pulses", shifts - s0, N);
    check("product", {24'd0, acc[7:0]}, exp_prod);
`ifdef SHIFT_ADD_CTRL_CYCLE_CNT_EN
    check("cycle_cnt", {24'd0, cyc}, exp_lat);
`endif
  endtask

  task automatic finish_op();
    start = 1'b0;
    step();
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int l0, a0, s0, n;

    // Reset held over several edges.
    repeat (3) step();
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_add", {31'd0, add}, 32'd0);
    check("rst_shift", {31'd0, shift}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef SHIFT_ADD_CTRL_CYCLE_CNT_EN
    check("rst_cycle_cnt", {24'd0, cyc}, 32'd0);
`endif
    rst_n = 1'b1;
    l0 = loads; a0 = adds; s0 = shifts;
    repeat (3) step();
    check("post_rst_pulses", (loads - l0) + (adds - a0) + (shifts - s0), 32'd0);

    // B = 0000: no adds, DONE at E0+9.
    run_op(4'd7, 4'b0000, 9, 0, 0, 1'b0);
    finish_op();

    // B = 1111 with A = 1111, start toggling while busy: DONE at E0+13, 225.
    run_op(4'b1111, 4'b1111, 13, 4, 225, 1'b1);
    finish_op();

    // B = 0101, start held through DONE: no retrigger.
    run_op(4'd3, 4'b0101, 11, 2, 15, 1'b0);
    l0 = loads;
    repeat (4) step();
    check("done_held", {31'd0, done}, 32'd1);
    check("no_retrigger", loads - l0, 32'd0);
    finish_op();

    // Re-raised start after the gap: a fresh operation.
    run_op(4'd9, 4'b0101, 11, 2, 45, 1'b0);
    finish_op();

    // Reset pulsed during the third SHIFT.
    a_op = 4'd5;
    b_op = 4'b0000;
    s0 = shifts;
    start = 1'b1;
    n = 0;
    while ((shifts - s0) < 3 && n < 40) begin
      step();
      n++;
    end
    check("third_shift_reached", {31'd0, shift}, 32'd1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_shift", {31'd0, shift}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_cmds", {29'd0, load, add, shift}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    l0 = loads; a0 = adds; s0 = shifts;
    repeat (4) step();
    check("rel_pulses", (loads - l0) + (adds - a0) + (shifts - s0), 32'd0);
    check("rel_busy", {31'd0, busy}, 32'd0);
    check("rel_done", {31'd0, done}, 32'd0);
`ifdef SHIFT_ADD_CTRL_CYCLE_CNT_EN
    check("rel_cycle_cnt", {24'd0, cyc}, 32'd0);
`endif

    // Normal operation after the mid-operation reset: 6 * 10 = 60.
    run_op(4'd6, 4'b1010, 11, 2, 60, 1'b0);
    finish_op();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
